// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I multi-cycle sequencer: opcodes, FSM states,
// writeback source codes and trap causes.
package rv32i_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } state_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_IMM = 2'd3
    } wb_sel_e;

    typedef enum logic [1:0] {
        TRAP_NONE    = 2'd0,
        TRAP_ILLEGAL = 2'd1,
        TRAP_BUS     = 2'd2,
        TRAP_ENV     = 2'd3
    } trap_cause_e;

    // Every legal opcode ends in 2'b11, so this also rejects compressed encodings.
    function automatic logic opcode_legal(input logic [6:0] opc);
        logic legal;
        case (opc)
            OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL,
            OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_FENCE, OPC_SYSTEM: legal = 1'b1;
            default:                                            legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/rv32i_multicycle_sequencer_if.sv
// Single-port memory handshake between the sequencer (master) and memory (slave).
interface rv32i_multicycle_sequencer_if;

    logic mem_req;
    logic mem_we;
    logic addr_sel;
    logic mem_ready;
    logic mem_rdata_valid;

    modport master (
        output mem_req,
        output mem_we,
        output addr_sel,
        input  mem_ready,
        input  mem_rdata_valid
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  addr_sel,
        output mem_ready,
        output mem_rdata_valid
    );

endinterface

// File: rtl/rv32i_multicycle_sequencer_alu_ctrl.sv
// Combinational ALU operand/operation selects derived from the instruction fields.
module rv32i_alu_ctrl
    import rv32i_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    output logic       sub_sra,
    output logic       alu_src_imm
);

    // SLT/SLTU compare via subtraction, hence the funct3 = 01x term.
    always_comb begin
        sub_sra     = 1'b0;
        alu_src_imm = 1'b1;
        case (opcode)
            OPC_OP: begin
                sub_sra     = funct7_b5 | (~funct3[2] & funct3[1]);
                alu_src_imm = 1'b0;
            end
            OPC_OP_IMM: begin
                sub_sra = ((funct3 == 3'b101) & funct7_b5) | (~funct3[2] & funct3[1]);
            end
            OPC_BRANCH: begin
                sub_sra     = 1'b1;
                alu_src_imm = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rv32i_multicycle_sequencer.sv
// Multi-cycle RV32I control FSM: fetch, decode, execute, memory and writeback
// over a shared single-port memory, with an optional bus-timeout trap.
module rv32i_multicycle_sequencer
    import rv32i_pkg::*;
#(
    parameter int unsigned STALL_LIMIT = 0,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic [31:0]                  INSN,
    input  logic                         branch_taken,
    rv32i_multicycle_sequencer_if.master mem_bus,
    output logic                         ir_load,
    output logic                         pc_load,
    output logic                         pc_next_sel,
    output logic                         pc_alu_sel,
    output logic                         sub_sra,
    output logic                         alu_src_imm,
    output logic [1:0]                   wb_sel,
    output logic                         rd_we,
    output logic                         halted,
    output logic [1:0]                   trap_cause
);

    localparam logic [CNT_W-1:0] STALL_MAX   = CNT_W'(STALL_LIMIT);
    localparam logic [CNT_W-1:0] CNT_SAT     = {CNT_W{1'b1}};
    localparam bit               STALL_CHECK = (STALL_LIMIT != 0);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              hold_q, hold_d;
    trap_cause_e       trap_cause_q, trap_cause_d;

    logic [6:0]        opcode;
    logic              is_store;
    logic              alu_sub_sra;
    logic              alu_imm;
    logic              stall_timeout;
    logic [CNT_W-1:0]  stall_next;
    logic              mem_req_c;
    logic              mem_we_c;
    logic              addr_sel_c;
    logic              unused_bits;

    assign opcode        = INSN[6:0];
    assign is_store      = (opcode == OPC_STORE);
    assign stall_timeout = STALL_CHECK && (stall_cnt_q == STALL_MAX) && !mem_bus.mem_ready;
    assign stall_next    = (stall_cnt_q == CNT_SAT) ? stall_cnt_q : stall_cnt_q + CNT_W'(1);
    assign unused_bits   = ^{INSN[31], INSN[29:15], INSN[11:7], mem_bus.mem_rdata_valid};

    rv32i_alu_ctrl u_alu_ctrl (
        .opcode      (opcode),
        .funct3      (INSN[14:12]),
        .funct7_b5   (INSN[30]),
        .sub_sra     (alu_sub_sra),
        .alu_src_imm (alu_imm)
    );

    // hold_q keeps FETCH quiet for one cycle after reset release and after a
    // store completes, so a request never starts right after mem_ready.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= ST_FETCH;
            stall_cnt_q  <= '0;
            hold_q       <= 1'b1;
            trap_cause_q <= TRAP_NONE;
        end else begin
            state_q      <= state_d;
            stall_cnt_q  <= stall_cnt_d;
            hold_q       <= hold_d;
            trap_cause_q <= trap_cause_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        stall_cnt_d  = stall_cnt_q;
        hold_d       = 1'b0;
        trap_cause_d = trap_cause_q;
        mem_req_c    = 1'b0;
        mem_we_c     = 1'b0;
        addr_sel_c   = 1'b0;
        ir_load      = 1'b0;
        pc_load      = 1'b0;
        pc_next_sel  = 1'b0;
        pc_alu_sel   = 1'b0;
        sub_sra      = 1'b0;
        alu_src_imm  = 1'b0;
        wb_sel       = WB_ALU;
        rd_we        = 1'b0;
        halted       = 1'b0;

        case (state_q)
            ST_FETCH: begin
                if (hold_q) begin
                    stall_cnt_d = '0;
                end else begin
                    mem_req_c = 1'b1;
                    if (mem_bus.mem_ready) begin
                        ir_load = 1'b1;
                        state_d = ST_DECODE;
                    end else if (stall_timeout) begin
                        state_d      = ST_TRAP;
                        trap_cause_d = TRAP_BUS;
                    end else begin
                        stall_cnt_d = stall_next;
                    end
                end
            end

            ST_DECODE: begin
                if (!opcode_legal(opcode)) begin
                    state_d      = ST_TRAP;
                    trap_cause_d = TRAP_ILLEGAL;
                end else begin
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                sub_sra     = alu_sub_sra;
                alu_src_imm = alu_imm;
                case (opcode)
                    OPC_LOAD, OPC_STORE: begin
                        state_d     = ST_MEM;
                        stall_cnt_d = '0;
                    end
                    OPC_BRANCH: begin
                        pc_load     = 1'b1;
                        pc_alu_sel  = branch_taken;
                        state_d     = ST_FETCH;
                        stall_cnt_d = '0;
                    end
                    OPC_FENCE: begin
                        pc_load     = 1'b1;
                        state_d     = ST_FETCH;
                        stall_cnt_d = '0;
                    end
                    OPC_SYSTEM: begin
                        state_d      = ST_TRAP;
                        trap_cause_d = TRAP_ENV;
                    end
                    default: state_d = ST_WB;
                endcase
            end

            ST_MEM: begin
                mem_req_c  = 1'b1;
                addr_sel_c = 1'b1;
                mem_we_c   = is_store;
                if (mem_bus.mem_ready) begin
                    if (is_store) begin
                        pc_load     = 1'b1;
                        state_d     = ST_FETCH;
                        stall_cnt_d = '0;
                        hold_d      = 1'b1;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (stall_timeout) begin
                    state_d      = ST_TRAP;
                    trap_cause_d = TRAP_BUS;
                end else begin
                    stall_cnt_d = stall_next;
                end
            end

            ST_WB: begin
                rd_we       = 1'b1;
                pc_load     = 1'b1;
                state_d     = ST_FETCH;
                stall_cnt_d = '0;
                case (opcode)
                    OPC_JAL: begin
                        pc_alu_sel = 1'b1;
                        wb_sel     = WB_PC4;
                    end
                    OPC_JALR: begin
                        pc_next_sel = 1'b1;
                        wb_sel      = WB_PC4;
                    end
                    OPC_LUI:  wb_sel = WB_IMM;
                    OPC_LOAD: wb_sel = WB_MEM;
                    default:  wb_sel = WB_ALU;
                endcase
            end

            ST_TRAP: begin
                halted = 1'b1;
            end

            default: state_d = ST_FETCH;
        endcase
    end

    assign mem_bus.mem_req  = mem_req_c;
    assign mem_bus.mem_we   = mem_we_c;
    assign mem_bus.addr_sel = addr_sel_c;
    assign trap_cause       = trap_cause_q;

endmodule

// File: tb/tb_rv32i_multicycle_sequencer.sv
// Self-checking bench: each instruction is expanded into an expected per-cycle
// control trace from its class and wait counts, then compared cycle by cycle.
module tb_rv32i_multicycle_sequencer;

    localparam int LIMIT = 4;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       addr_sel;
        logic       ir_load;
        logic       pc_load;
        logic       pc_next_sel;
        logic       pc_alu_sel;
        logic       sub_sra;
        logic       alu_src_imm;
        logic [1:0] wb_sel;
        logic       rd_we;
        logic       halted;
        logic [1:0] trap_cause;
    } ctl_t;

    typedef enum int {
        K_OP, K_OPIMM, K_LOAD, K_STORE, K_BRANCH, K_JAL, K_JALR,
        K_LUI, K_AUIPC, K_FENCE, K_SYS, K_BAD
    } kind_e;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [31:0] INSN = 32'h0;
    logic        branch_taken = 1'b0;
    logic        ir_load, pc_load, pc_next_sel, pc_alu_sel, sub_sra, alu_src_imm;
    logic [1:0]  wb_sel;
    logic        rd_we, halted;
    logic [1:0]  trap_cause;

    int total = 0;
    int bad   = 0;
    bit bubble_pending = 1'b0;

    logic [6:0] opc_tab [0:10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                   7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                   7'b0010111, 7'b0001111, 7'b1110011};

    rv32i_multicycle_sequencer_if bus ();

    rv32i_multicycle_sequencer #(
        .STALL_LIMIT (LIMIT),
        .CNT_W       (8)
    ) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .INSN         (INSN),
        .branch_taken (branch_taken),
        .mem_bus      (bus),
        .ir_load      (ir_load),
        .pc_load      (pc_load),
        .pc_next_sel  (pc_next_sel),
        .pc_alu_sel   (pc_alu_sel),
        .sub_sra      (sub_sra),
        .alu_src_imm  (alu_src_imm),
        .wb_sel       (wb_sel),
        .rd_we        (rd_we),
        .halted       (halted),
        .trap_cause   (trap_cause)
    );

    always #5 CLK = ~CLK;

    function automatic ctl_t observed();
        ctl_t c;
        c.mem_req     = bus.mem_req;
        c.mem_we      = bus.mem_we;
        c.addr_sel    = bus.addr_sel;
        c.ir_load     = ir_load;
        c.pc_load     = pc_load;
        c.pc_next_sel = pc_next_sel;
        c.pc_alu_sel  = pc_alu_sel;
        c.sub_sra     = sub_sra;
        c.alu_src_imm = alu_src_imm;
        c.wb_sel      = wb_sel;
        c.rd_we       = rd_we;
        c.halted      = halted;
        c.trap_cause  = trap_cause;
        return c;
    endfunction

    function automatic kind_e kindOf(input logic [31:0] insn);
        for (int k = 0; k < 11; k++)
            if (insn[6:0] == opc_tab[k]) return kind_e'(k);
        return K_BAD;
    endfunction

    function automatic logic noise();
        return logic'($urandom_range(0, 1));
    endfunction

    task automatic checkOutput(input string tag, input logic [14:0] obs, input logic [14:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h want=%h insn=%h t=%0t", tag, obs, exp, INSN, $time);
        end
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic stepCycle(input string tag, input logic rdy, input ctl_t exp);
        bus.mem_ready = rdy;
        @(negedge CLK);
        checkOutput(tag, observed(), exp);
        @(posedge CLK);
        #1;
    endtask

    task automatic checkTrap(input logic [1:0] cause, input int n);
        ctl_t e;
        e = '0;
        e.halted     = 1'b1;
        e.trap_cause = cause;
        repeat (n) stepCycle("trap", noise(), e);
    endtask

    task automatic doReset(input string tag);
        bus.mem_ready = 1'b0;
        RST_N = 1'b0;
        #1;
        checkOutput(tag, observed(), '0);
        repeat (2) @(posedge CLK);
        #1;
        checkOutput(tag, observed(), '0);
        RST_N = 1'b1;
        bubble_pending = 1'b1;
    endtask

    // One instruction: fw/mw are wait cycles before mem_ready in fetch/memory.
    task automatic applyStimulus(input logic [31:0] insn, input int fw, input int mw,
                                 input logic taken, input bit cut_mem, output bit needs_reset);
        ctl_t  e;
        kind_e k;
        logic [2:0] f3;
        k  = kindOf(insn);
        f3 = insn[14:12];
        needs_reset  = 1'b0;
        INSN         = insn;
        branch_taken = taken;

        if (bubble_pending) begin
            stepCycle("idle", noise(), '0);
            bubble_pending = 1'b0;
        end

        for (int i = 0; i <= fw; i++) begin
            if (i > LIMIT) begin
                checkTrap(2'd2, 3);
                needs_reset = 1'b1;
                return;
            end
            e = '0;
            e.mem_req = 1'b1;
            e.ir_load = (i == fw);
            stepCycle("fetch", i == fw, e);
        end

        stepCycle("decode", noise(), '0);
        if (k == K_BAD) begin
            checkTrap(2'd1, 3);
            needs_reset = 1'b1;
            return;
        end

        e = '0;
        case (k)
            K_OP:     e.sub_sra = insn[30] || (f3 == 3'd2) || (f3 == 3'd3);
            K_OPIMM:  e.sub_sra = ((f3 == 3'd5) && insn[30]) || (f3 == 3'd2) || (f3 == 3'd3);
            K_BRANCH: e.sub_sra = 1'b1;
            default:  e.sub_sra = 1'b0;
        endcase
        e.alu_src_imm = !(k == K_OP || k == K_BRANCH);
        if (k == K_BRANCH) begin
            e.pc_load    = 1'b1;
            e.pc_alu_sel = taken;
        end
        if (k == K_FENCE) e.pc_load = 1'b1;
        stepCycle("exec", noise(), e);

        if (k == K_SYS) begin
            checkTrap(2'd3, 3);
            needs_reset = 1'b1;
            return;
        end
        if (k == K_BRANCH || k == K_FENCE) return;

        if (k == K_LOAD || k == K_STORE) begin
            for (int i = 0; i <= mw; i++) begin
                if (cut_mem && i == 2) begin
                    bus.mem_ready = 1'b0;
                    #2;
                    doReset("rst_mid_mem");
                    return;
                end
                if (i > LIMIT) begin
                    checkTrap(2'd2, 3);
                    needs_reset = 1'b1;
                    return;
                end
                e = '0;
                e.mem_req  = 1'b1;
                e.addr_sel = 1'b1;
                e.mem_we   = (k == K_STORE);
                e.pc_load  = (k == K_STORE) && (i == mw);
                stepCycle("mem", i == mw, e);
            end
            if (k == K_STORE) begin
                bubble_pending = 1'b1;
                return;
            end
        end

        e = '0;
        e.rd_we   = 1'b1;
        e.pc_load = 1'b1;
        case (k)
            K_JAL:   begin e.pc_alu_sel  = 1'b1; e.wb_sel = 2'd2; end
            K_JALR:  begin e.pc_next_sel = 1'b1; e.wb_sel = 2'd2; end
            K_LUI:   e.wb_sel = 2'd3;
            K_LOAD:  e.wb_sel = 2'd1;
            default: e.wb_sel = 2'd0;
        endcase
        stepCycle("wb", noise(), e);
    endtask

    task automatic runOne(input logic [31:0] insn, input int fw, input int mw,
                          input logic taken, input bit cut_mem);
        bit nr;
        applyStimulus(insn, fw, mw, taken, cut_mem, nr);
        if (nr) doReset("reset_after_trap");
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [6:0]  opc;
        int          fw, mw;

        bus.mem_ready       = 1'b0;
        bus.mem_rdata_valid = 1'b0;
        @(posedge CLK);
        #1;
        doReset("reset");

        runOne(32'h002081B3, 0, 0, 1'b0, 1'b0);   // ADD
        runOne(32'h402081B3, 0, 0, 1'b0, 1'b0);   // SUB
        runOne(32'h0000A183, 0, 3, 1'b0, 1'b0);   // LW, 3 wait cycles
        runOne(32'h00208463, 0, 0, 1'b1, 1'b0);   // BEQ taken
        runOne(32'h00208463, 1, 0, 1'b0, 1'b0);   // BEQ not taken
        runOne(32'h0030A023, 0, 1, 1'b0, 1'b0);   // SW
        runOne(32'h008000EF, 2, 0, 1'b0, 1'b0);   // JAL
        runOne(32'h000080E7, 0, 0, 1'b0, 1'b0);   // JALR
        runOne(32'h123450B7, 0, 0, 1'b0, 1'b0);   // LUI
        runOne(32'h00001097, 4, 0, 1'b0, 1'b0);   // AUIPC, wait at the limit
        runOne(32'h0000000F, 0, 0, 1'b0, 1'b0);   // FENCE
        runOne(32'h4020D093, 0, 0, 1'b0, 1'b0);   // SRAI
        runOne(32'h0020A093, 0, 0, 1'b0, 1'b0);   // SLTI
        runOne(32'h0000A183, 0, 4, 1'b0, 1'b0);   // LW, wait at the limit
        runOne(32'h0000007F, 0, 0, 1'b0, 1'b0);   // illegal opcode
        runOne(32'h00000073, 0, 0, 1'b0, 1'b0);   // ECALL
        runOne(32'h002081B3, 99, 0, 1'b0, 1'b0);  // fetch timeout
        runOne(32'h0030A023, 0, 99, 1'b0, 1'b0);  // store timeout
        runOne(32'h0030A023, 0, 99, 1'b0, 1'b1);  // reset mid store
        runOne(32'h002081B3, 0, 0, 1'b0, 1'b0);

        for (int n = 0; n < 120; n++) begin
            r  = $urandom;
            fw = $urandom_range(0, LIMIT);
            mw = $urandom_range(0, LIMIT);
            if ($urandom_range(0, 24) == 0) mw = 99;
            if ($urandom_range(0, 11) == 0) begin
                opc = 7'($urandom);
                for (int t = 0; t < 50 && kindOf({25'h0, opc}) != K_BAD; t++)
                    opc = 7'($urandom);
                if (kindOf({25'h0, opc}) != K_BAD) opc = 7'h7F;
                if ($urandom_range(0, 1) == 0) opc = 7'b1110011;
            end else begin
                opc = opc_tab[$urandom_range(0, 9)];
            end
            runOne({r[31:7], opc}, fw, mw, logic'($urandom_range(0, 1)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
